// File: rtl/q_8_34a_ctrl.sv
// q_8_34a_ctrl: control unit for the count-ones datapath.
//
// This block sequences the datapath's load_regs, incr_r2 and shift controls using the
// zero and E status flags. It adds a start/ready/done handshake and a result register
// that holds the most recent ones count.
//
// Ports
//   clk, rst_b          clock (rising edge) and asynchronous active-low reset
//   start               request; sampled only while ready=1
//   zero, E, cnt        datapath status: r1==0, last bit shifted out, r2 value
//   load_regs, incr_r2,
//   shift               datapath controls, decoded from state (never registered)
//   ready               high in IDLE
//   done                one-cycle registered pulse when result updates
//   result              captured ones count, held until the next completion
//
// Optional feature (macro Q_8_34A_CTRL_ABORT_EN)
//   abort               input: cancels a busy operation, returns to IDLE
//   aborted             output: registered one-cycle pulse after an abort
module q_8_34a_ctrl #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned R2_SIZE   = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic               zero,
  input  logic               E,
  input  logic [R2_SIZE-1:0] cnt,
`ifdef Q_8_34A_CTRL_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               load_regs,
  output logic               incr_r2,
  output logic               shift,
  output logic               ready,
  output logic               done,
  output logic [R2_SIZE-1:0] result
);

  // r2 must count to DATA_SIZE starting from all-ones+1 without wrapping.
  if ((2 ** R2_SIZE) <= DATA_SIZE) begin : g_bad_params
    $error("q_8_34a_ctrl: 2**R2_SIZE must exceed DATA_SIZE");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INCR = 2'd1;
  localparam logic [1:0] TEST = 2'd2;
  localparam logic [1:0] CHK  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               done_q, done_d;
  logic [R2_SIZE-1:0] result_q, result_d;
  logic               abort_act;

`ifdef Q_8_34A_CTRL_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_act = abort && (state_q != IDLE);
  assign aborted   = aborted_q;
`else
  assign abort_act = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    result_d  = result_q;
`ifdef Q_8_34A_CTRL_ABORT_EN
    aborted_d = 1'b0;
`endif
    load_regs = 1'b0;
    incr_r2   = 1'b0;
    shift     = 1'b0;
    ready     = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          // Gate with rst_b so the datapath never sees a load while reset is held.
          load_regs = rst_b;
          state_d   = INCR;
        end
      end
      INCR: begin
        if (abort_act) begin
          state_d = IDLE;
        end else begin
          incr_r2 = 1'b1;
          state_d = TEST;
        end
      end
      TEST: begin
        // Abort wins over a completion in the same cycle.
        if (abort_act) begin
          state_d = IDLE;
        end else if (zero) begin
          done_d   = 1'b1;
          result_d = cnt;
          state_d  = IDLE;
        end else begin
          shift   = 1'b1;
          state_d = CHK;
        end
      end
      CHK: begin
        if (abort_act) begin
          state_d = IDLE;
        end else begin
          state_d = E ? INCR : TEST;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef Q_8_34A_CTRL_ABORT_EN
    aborted_d = abort_act;
`endif
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      result_q  <= '0;
`ifdef Q_8_34A_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      result_q  <= result_d;
`ifdef Q_8_34A_CTRL_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_q_8_34a_ctrl.sv
// Testbench for q_8_34a_ctrl: a behavioural count-ones datapath plus a scoreboard.
// Each issued operand pushes its expected result, busy-cycle count, incr_r2 count and shift
// count into a queue. A monitor pops one entry on every done pulse and compares it.
module tb_q_8_34a_ctrl;
  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       zero, E;
  logic [3:0] cnt;
  logic       load_regs, incr_r2, shift, ready, done;
  logic [3:0] result;
`ifdef Q_8_34A_CTRL_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif

  q_8_34a_ctrl #(.DATA_SIZE(8), .R2_SIZE(4)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .zero(zero), .E(E), .cnt(cnt),
`ifdef Q_8_34A_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .load_regs(load_regs), .incr_r2(incr_r2), .shift(shift),
    .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Datapath model: incr_r2 overrides load_regs on r2.
  logic [7:0] r1;
  logic [3:0] r2;
  logic       e_q;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r1  <= '0;
      r2  <= '0;
      e_q <= 1'b0;
    end else begin
      if (incr_r2) r2 <= r2 + 4'd1;
      else if (load_regs) r2 <= '1;
      if (load_regs) r1 <= data_in;
      else if (shift) {e_q, r1} <= {r1, 1'b0};
    end
  end
  assign zero = (r1 == 8'h00);
  assign E    = e_q;
  assign cnt  = r2;

  typedef struct {
    logic [3:0] res;
    int         busy;
    int         incs;
    int         shs;
    string      name;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor: one-hot check every cycle, and a scoreboard pop on each done pulse.
  initial begin
    int   busy_n, inc_n, sh_n;
    exp_t e;
    busy_n = 0; inc_n = 0; sh_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        busy_n = 0; inc_n = 0; sh_n = 0;
      end else begin
        chk("ctrl_onehot", 32'($countones({load_regs, incr_r2, shift}) <= 1), 32'd1);
        if (done) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, 32'(result), 32'(e.res));
            chk({e.name, "_busy"}, busy_n, e.busy);
            chk({e.name, "_incr"}, inc_n, e.incs);
            chk({e.name, "_shift"}, sh_n, e.shs);
          end
        end
        if (load_regs) begin
          busy_n = 0; inc_n = 0; sh_n = 0;
        end else begin
          if (!ready) busy_n++;
          if (incr_r2) inc_n++;
          if (shift) sh_n++;
        end
      end
    end
  end

  // Returns at the negedge of the done cycle; n counts cycles after the start cycle.
  task automatic wait_done(input string name, output int n);
    bit seen;
    seen = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [3:0] res, input int busy,
                        input int incs, input int shs, input string name, output int n);
    sb.push_back('{res, busy, incs, shs, name});
    @(posedge clk); #1;
    start = 1'b1;
    data_in = op;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name, n);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ctrl", 32'({load_regs, incr_r2, shift}), 32'd0);
    #21 rst_b = 1'b1;

    run_op(8'h00, 4'd0, 2, 1, 0, "op00", n);
    chk("op00_latency", n, 3);
    run_op(8'hFF, 4'd8, 26, 9, 8, "opFF", n);
    run_op(8'h80, 4'd1, 5, 2, 1, "op80", n);
    run_op(8'h01, 4'd1, 19, 2, 8, "op01", n);

    // Reset during TEST, with start high to confirm load_regs is held off.
    @(posedge clk); #1;
    start = 1'b1;
    data_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    start = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_ctrl", 32'({load_regs, incr_r2, shift}), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    #1 rst_b = 1'b1;
    repeat (30) @(negedge clk);
    chk("postrst_result", 32'(result), 32'd0);

    // Back-to-back: start held through done; second load lands in the done cycle.
    sb.push_back('{4'd4, 22, 5, 8, "opA5"});
    sb.push_back('{4'd4, 22, 5, 8, "op0F"});
    @(posedge clk); #1;
    start = 1'b1;
    data_in = 8'hA5;
    @(posedge clk); #1;
    data_in = 8'h0F;
    wait_done("opA5", n);
    chk("b2b_load_in_done", 32'(load_regs), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("op0F", n);

`ifdef Q_8_34A_CTRL_ABORT_EN
    // Abort on the 5th busy cycle (second TEST) of an FF run.
    @(posedge clk); #1;
    start = 1'b1;
    data_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    #1;
    chk("abort_ctrl", 32'({load_regs, incr_r2, shift}), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd4);
    @(posedge clk); #1;
    chk("abort_pulse_end", 32'(aborted), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
